// File: rtl/mem_access_unit.sv
// MEM stage of the pipelined MIPS core: req/ack data-memory access, pipeline stall and the
// MEM/WB register. Define MEM_TIMEOUT_EN to abort accesses that wait TIMEOUT cycles for dm_ack.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [4:0]  mrn,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn,
  output logic        err
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wwreg_q, wwreg_d;
  logic        wm2reg_q, wm2reg_d;
  logic [31:0] wmo_q, wmo_d;
  logic [31:0] walu_q, walu_d;
  logic [4:0]  wrn_q, wrn_d;
  logic        err_q, err_d;

  logic memop;
  logic misal;
  logic launch;
  logic tmo;
  logic stall_c;

  assign memop  = mm2reg | mwmem;
  assign misal  = memop & (malu[1:0] != 2'b00);
  assign launch = (state_q == StIdle) & memop & ~misal;

  // The counter must be able to hold TIMEOUT-1 and TIMEOUT must be non-zero.
  if ((TIMEOUT == 0) || ((TIMEOUT >> TW) != 0)) begin : g_bad_cfg
    $error("mem_access_unit: TIMEOUT must be in 1 .. 2**TW-1");
  end

`ifdef MEM_TIMEOUT_EN
  logic [TW-1:0] cnt_q, cnt_d;

  // Abort on the TIMEOUT-th BUSY cycle without an ack; an ack in that cycle wins.
  assign tmo = (state_q == StBusy) & ~dm_ack & (cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (launch) begin
      cnt_d = '0;
    end else if ((state_q == StBusy) && !dm_ack) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  // Access FSM and memory-side request registers.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    stall_c = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          stall_c = 1'b1;
          state_d = StBusy;
          req_d   = 1'b1;
          we_d    = mwmem;
          addr_d  = {malu[31:2], 2'b00};
          wdata_d = mb;
        end else if (misal) begin
          err_d = 1'b1;
        end
      end
      StBusy: begin
        stall_c = ~dm_ack & ~tmo;
        if (dm_ack) begin
          state_d = StIdle;
          req_d   = 1'b0;
        end else if (tmo) begin
          state_d = StIdle;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  // MEM/WB register: a stalled cycle becomes a bubble so the instruction writes back once.
  always_comb begin
    wwreg_d  = wwreg_q;
    wm2reg_d = wm2reg_q;
    wmo_d    = wmo_q;
    walu_d   = walu_q;
    wrn_d    = wrn_q;
    if (stall_c) begin
      wwreg_d  = 1'b0;
      wm2reg_d = 1'b0;
    end else if (tmo) begin
      wwreg_d  = 1'b0;
      wm2reg_d = 1'b0;
      wmo_d    = '0;
      walu_d   = malu;
      wrn_d    = mrn;
    end else begin
      wwreg_d  = mwreg & ~misal;
      wm2reg_d = mm2reg & ~misal;
      walu_d   = malu;
      wrn_d    = mrn;
      wmo_d    = ((state_q == StBusy) && dm_ack && mm2reg) ? dm_rdata : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= StIdle;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wwreg_q  <= 1'b0;
      wm2reg_q <= 1'b0;
      wmo_q    <= '0;
      walu_q   <= '0;
      wrn_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wwreg_q  <= wwreg_d;
      wm2reg_q <= wm2reg_d;
      wmo_q    <= wmo_d;
      walu_q   <= walu_d;
      wrn_q    <= wrn_d;
      err_q    <= err_d;
    end
  end

  assign dm_req   = req_q;
  assign dm_we    = we_q;
  assign dm_addr  = addr_q;
  assign dm_wdata = wdata_q;
  assign stall    = stall_c;
  assign wwreg    = wwreg_q;
  assign wm2reg   = wm2reg_q;
  assign wmo      = wmo_q;
  assign walu     = walu_q;
  assign wrn      = wrn_q;
  assign err      = err_q;

  a_addr_aligned: assert property (@(posedge clk) disable iff (!clrn)
    req_q |-> (addr_q[1:0] == 2'b00));

  a_req_stable: assert property (@(posedge clk) disable iff (!clrn)
    (req_q && !dm_ack && !tmo) |=>
      (req_q && $stable(addr_q) && $stable(we_q) && $stable(wdata_q)));

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table for single-cycle cases plus hand-written
// sequences for loads, stores, back-to-back access, reset mid-access and timeout.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        clrn;
  logic        mwreg, mm2reg, mwmem;
  logic [31:0] malu, mb;
  logic [4:0]  mrn;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        stall, wwreg, wm2reg;
  logic [31:0] wmo, walu;
  logic [4:0]  wrn;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(
    .TIMEOUT(4),
    .TW     (8)
  ) dut (
    .clk     (clk),
    .clrn    (clrn),
    .mwreg   (mwreg),
    .mm2reg  (mm2reg),
    .mwmem   (mwmem),
    .malu    (malu),
    .mb      (mb),
    .mrn     (mrn),
    .dm_req  (dm_req),
    .dm_we   (dm_we),
    .dm_addr (dm_addr),
    .dm_wdata(dm_wdata),
    .dm_ack  (dm_ack),
    .dm_rdata(dm_rdata),
    .stall   (stall),
    .wwreg   (wwreg),
    .wm2reg  (wm2reg),
    .wmo     (wmo),
    .walu    (walu),
    .wrn     (wrn),
    .err     (err)
  );

  typedef struct {
    logic        mwreg;
    logic        mm2reg;
    logic        mwmem;
    logic [31:0] malu;
    logic [31:0] mb;
    logic [4:0]  mrn;
    logic        e_wwreg;
    logic        e_wm2reg;
    logic [31:0] e_walu;
    logic [4:0]  e_wrn;
    logic        e_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setin(input logic wr, input logic ld, input logic st, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rn, input logic ack,
                       input logic [31:0] rd);
    mwreg    = wr;
    mm2reg   = ld;
    mwmem    = st;
    malu     = a;
    mb       = b;
    mrn      = rn;
    dm_ack   = ack;
    dm_rdata = rd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dm_req"}, dm_req, 0);
    chk({tag, "_dm_we"}, dm_we, 0);
    chk({tag, "_dm_addr"}, dm_addr, 0);
    chk({tag, "_dm_wdata"}, dm_wdata, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_wwreg"}, wwreg, 0);
    chk({tag, "_wm2reg"}, wm2reg, 0);
    chk({tag, "_wmo"}, wmo, 0);
    chk({tag, "_walu"}, walu, 0);
    chk({tag, "_wrn"}, wrn, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    //           wr    ld    st    malu           mb            rn    wwreg wm2r  walu           wrn    err
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0,       5'd5,  1'b1, 1'b0, 32'h0000_1234, 5'd5,  1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h11,      5'd31, 1'b0, 1'b0, 32'hFFFF_FFFF, 5'd31, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_0003, 32'h0,       5'd1,  1'b1, 1'b0, 32'h0000_0003, 5'd1,  1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0,       5'd8,  1'b0, 1'b0, 32'h0000_0102, 5'd8,  1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0055, 32'h0,       5'd2,  1'b1, 1'b0, 32'h0000_0055, 5'd2,  1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0000_0201, 32'h5A5A,    5'd0,  1'b0, 1'b0, 32'h0000_0201, 5'd0,  1'b1};

    clrn = 1'b0;
    setin(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    #12;
    chk_all_zero("rst");
    clrn = 1'b1;
    tick();

    // Single-cycle pass-through and misaligned cases.
    for (int i = 0; i < 6; i++) begin
      setin(vecs[i].mwreg, vecs[i].mm2reg, vecs[i].mwmem, vecs[i].malu, vecs[i].mb, vecs[i].mrn,
            0, 32'hFFFF_0000);
      #1;
      chk($sformatf("v%0d_stall", i), stall, 0);
      tick();
      chk($sformatf("v%0d_dm_req", i), dm_req, 0);
      chk($sformatf("v%0d_wwreg", i), wwreg, vecs[i].e_wwreg);
      chk($sformatf("v%0d_wm2reg", i), wm2reg, vecs[i].e_wm2reg);
      chk($sformatf("v%0d_walu", i), walu, vecs[i].e_walu);
      chk($sformatf("v%0d_wrn", i), wrn, vecs[i].e_wrn);
      chk($sformatf("v%0d_wmo", i), wmo, 0);
      chk($sformatf("v%0d_err", i), err, vecs[i].e_err);
    end

    // Sticky err clears only on reset.
    setin(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    #1 clrn = 1'b0;
    #1 chk_all_zero("rst2");
    clrn = 1'b1;
    tick();

    // Load, ack in the third BUSY cycle.
    setin(1, 1, 0, 32'h100, 32'h0, 5'd8, 0, 32'hDEAD_BEEF);
    #1 chk("ld_stall_req_cycle", stall, 1);
    chk("ld_no_req_yet", dm_req, 0);
    tick();
    chk("ld_dm_req", dm_req, 1);
    chk("ld_dm_addr", dm_addr, 32'h100);
    chk("ld_dm_we", dm_we, 0);
    chk("ld_bubble1", wwreg, 0);
    chk("ld_stall_busy1", stall, 1);
    tick();
    chk("ld_bubble2", wwreg, 0);
    chk("ld_stall_busy2", stall, 1);
    chk("ld_req_held", dm_req, 1);
    tick();
    chk("ld_bubble3", wwreg, 0);
    dm_ack = 1'b1;
    #1 chk("ld_stall_ack", stall, 0);
    tick();
    chk("ld_wwreg", wwreg, 1);
    chk("ld_wm2reg", wm2reg, 1);
    chk("ld_wmo", wmo, 32'hDEAD_BEEF);
    chk("ld_wrn", wrn, 8);
    chk("ld_walu", walu, 32'h100);
    chk("ld_req_drop", dm_req, 0);
    setin(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    #1 chk("nop_stall", stall, 0);
    tick();
    chk("nop_wmo", wmo, 0);
    chk("nop_wwreg", wwreg, 0);

    // Store then load back-to-back, minimum-latency acks.
    setin(0, 0, 1, 32'h200, 32'hA5A5_A5A5, 5'd0, 0, 32'h0);
    #1 chk("st_stall", stall, 1);
    tick();
    chk("st_dm_req", dm_req, 1);
    chk("st_dm_we", dm_we, 1);
    chk("st_dm_addr", dm_addr, 32'h200);
    chk("st_dm_wdata", dm_wdata, 32'hA5A5_A5A5);
    dm_ack = 1'b1;
    #1 chk("st_stall_ack", stall, 0);
    tick();
    chk("st_req_drop", dm_req, 0);
    chk("st_wwreg", wwreg, 0);
    chk("st_wmo", wmo, 0);
    setin(1, 1, 0, 32'h204, 32'h0, 5'd9, 0, 32'h1234_5678);
    #1 chk("b2b_stall", stall, 1);
    chk("b2b_single_req", dm_req, 0);
    tick();
    chk("b2b_dm_req", dm_req, 1);
    chk("b2b_dm_addr", dm_addr, 32'h204);
    chk("b2b_dm_we", dm_we, 0);
    dm_ack = 1'b1;
    tick();
    chk("b2b_wwreg", wwreg, 1);
    chk("b2b_wmo", wmo, 32'h1234_5678);
    chk("b2b_wrn", wrn, 9);
    chk("b2b_req_drop", dm_req, 0);

    // Stray ack while idle is ignored.
    setin(0, 0, 0, 32'h0, 32'h0, 5'd0, 1, 32'hCAFE_F00D);
    #1 chk("idle_ack_stall", stall, 0);
    tick();
    chk("idle_ack_wmo", wmo, 0);
    chk("idle_ack_req", dm_req, 0);

    // Reset during BUSY; a late ack must not write back.
    setin(1, 0, 0, 32'h777, 32'h0, 5'd3, 0, 32'h0);
    tick();
    chk("pre_rst_walu", walu, 32'h777);
    setin(1, 1, 0, 32'h300, 32'h0, 5'd4, 0, 32'h0);
    tick();
    chk("mid_req", dm_req, 1);
    #2;
    clrn = 1'b0;
    setin(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    #1 chk_all_zero("mid_rst");
    #2 clrn = 1'b1;
    setin(0, 0, 0, 32'h0, 32'h0, 5'd0, 1, 32'hBADB_AD00);
    #1 chk("late_ack_stall", stall, 0);
    tick();
    chk("late_ack_wwreg", wwreg, 0);
    chk("late_ack_wmo", wmo, 0);
    chk("late_ack_req", dm_req, 0);

    setin(1, 1, 0, 32'h400, 32'h0, 5'd10, 0, 32'h0);
    #1 chk("to_stall_req", stall, 1);
    tick();
    chk("to_dm_req", dm_req, 1);
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("to_stall_busy%0d", i + 1), stall, 1);
      tick();
      chk($sformatf("to_req_busy%0d", i + 2), dm_req, 1);
    end
    chk("to_stall_abort", stall, 0);
    tick();
    chk("to_req_drop", dm_req, 0);
    chk("to_wwreg", wwreg, 0);
    chk("to_wmo", wmo, 0);
    chk("to_err", err, 1);
    setin(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    tick();
    chk("to_err_sticky", err, 1);
`else
    // Without the timeout, BUSY waits as long as the memory takes.
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("wait_stall%0d", i), stall, 1);
      tick();
      chk($sformatf("wait_req%0d", i), dm_req, 1);
    end
    dm_ack   = 1'b1;
    dm_rdata = 32'h0BAD_F00D;
    #1 chk("wait_stall_ack", stall, 0);
    tick();
    chk("wait_wwreg", wwreg, 1);
    chk("wait_wmo", wmo, 32'h0BAD_F00D);
    chk("wait_err", err, 0);
    setin(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
